// File: rtl/uart_pkg.sv
// Shared definitions for the 7N1 UART transmitter: FSM state encoding,
// default framing constants and a counter-width helper.
package uart_pkg;

  localparam int unsigned UART_WORD_SIZE    = 8;
  localparam int unsigned UART_DATA_BITS    = 7;
  localparam int unsigned UART_CLKS_PER_BIT = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  // Width needed to count 0..n-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts clk_i cycles and flags the last cycle of each
// period; restart_i forces the count back to zero.
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int unsigned p_clks_per_bit = UART_CLKS_PER_BIT
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic restart_i,
  output logic done_o
);

  localparam int unsigned CW = cnt_width(p_clks_per_bit);
  localparam logic [CW-1:0] LAST = CW'(p_clks_per_bit - 1);

  logic [CW-1:0] cnt_q;

  // Wrapping on done_o lets consecutive periods in one state chain seamlessly.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (restart_i || done_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign done_o = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter pulling words from a first-word-fall-through FIFO and
// sending p_data_bits data bits LSB first with one start and one stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned p_word_size    = UART_WORD_SIZE,
  parameter int unsigned p_data_bits    = UART_DATA_BITS,
  parameter int unsigned p_clks_per_bit = UART_CLKS_PER_BIT
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [p_word_size-1:0] fifo_data_i,
  input  logic                   fifo_valid_i,
  output logic                   fifo_read_o,
  input  logic                   tx_enable_i,
  output logic                   tx_o,
  output logic                   busy_o
);

  // FIFO handshake: fifo_valid_i means fifo_data_i holds the head word; a
  // one-cycle fifo_read_o consumes it on the same rising edge.

  localparam int unsigned BW = cnt_width(p_data_bits);
  localparam logic [BW-1:0] LAST_BIT = BW'(p_data_bits - 1);

  uart_state_e            state_q, state_d;
  logic [p_data_bits-1:0] shift_q, shift_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic                   tx_q, tx_d;
  logic                   pop;
  logic                   baud_done;
  logic                   baud_restart;

  assign pop         = (state_q == ST_IDLE) & fifo_valid_i & tx_enable_i & rst_n_i;
  assign fifo_read_o = pop;
  assign busy_o      = (state_q != ST_IDLE);
  assign tx_o        = tx_q;

  generate
    if (p_word_size > p_data_bits) begin : g_unused_upper
      logic unused_upper;
      assign unused_upper = ^fifo_data_i[p_word_size-1:p_data_bits];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          state_d = ST_START;
          shift_d = fifo_data_i[p_data_bits-1:0];
          bit_d   = '0;
        end
      end
      ST_START: begin
        if (baud_done) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (baud_done) begin
          shift_d = shift_q >> 1;
          if (bit_q == LAST_BIT) begin
            state_d = ST_STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      ST_STOP: begin
        if (baud_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The line value is derived from the next state so tx_o changes on the
  // same edge the state does.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  // Hold the timer at zero in IDLE and restart it on every state entry.
  assign baud_restart = (state_q == ST_IDLE) | (state_d != state_q);

  uart_baud_counter #(
    .p_clks_per_bit(p_clks_per_bit)
  ) u_baud (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .restart_i(baud_restart),
    .done_o   (baud_done)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a FIFO model feeds words, and a per-cycle expected
// queue of {busy, tx} built from the frame format is compared every cycle.
module tb_uart_tx;

  localparam int WS    = 8;
  localparam int DB    = 7;
  localparam int CPB   = 4;
  localparam int FRAME = (DB + 2) * CPB;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [WS-1:0] fifo_data;
  logic          fifo_valid;
  logic          fifo_read;
  logic          tx_enable;
  logic          tx;
  logic          busy;

  uart_tx #(
    .p_word_size   (WS),
    .p_data_bits   (DB),
    .p_clks_per_bit(CPB)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .fifo_data_i (fifo_data),
    .fifo_valid_i(fifo_valid),
    .fifo_read_o (fifo_read),
    .tx_enable_i (tx_enable),
    .tx_o        (tx),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  logic [WS-1:0] fifo_q[$];
  logic [1:0]    exp_q[$];   // {busy, tx} expected for each upcoming cycle
  int            pop_cyc[$];
  logic          fifo_gate;
  int total = 0, bad = 0, cyc = 0;
  int dut_pops = 0, model_pops = 0, busy_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic void drive_fifo();
    fifo_valid = fifo_gate && (fifo_q.size() > 0);
    fifo_data  = (fifo_q.size() > 0) ? fifo_q[0] : WS'($urandom);
  endfunction

  // Start bit, DB data bits LSB first, one stop bit, each CPB cycles long.
  function automatic void push_frame(input logic [WS-1:0] w);
    for (int k = 0; k < CPB; k++) exp_q.push_back(2'b10);
    for (int b = 0; b < DB; b++)
      for (int k = 0; k < CPB; k++) exp_q.push_back({1'b1, w[b]});
    for (int k = 0; k < CPB; k++) exp_q.push_back(2'b11);
  endfunction

  task automatic cycle();
    logic       exp_rd;
    logic [1:0] exp_bt;
    @(negedge clk);
    exp_bt = (exp_q.size() > 0) ? exp_q[0] : 2'b01;
    exp_rd = (exp_q.size() == 0) && fifo_valid && tx_enable && rst_n;
    check("fifo_read", fifo_read, exp_rd);
    check("tx", tx, exp_bt[0]);
    check("busy", busy, exp_bt[1]);
    if (fifo_read === 1'b1) begin
      dut_pops++;
      pop_cyc.push_back(cyc);
    end
    if (busy === 1'b1) busy_cnt++;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    if (!rst_n) begin
      exp_q.delete();
    end else if (exp_rd) begin
      push_frame(fifo_q.pop_front());
      model_pops++;
    end
    @(posedge clk);
    #1;
    cyc++;
    drive_fifo();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  initial begin
    int start_pops;
    int guard;
    rst_n      = 1'b0;
    tx_enable  = 1'b0;
    fifo_gate  = 1'b1;
    fifo_valid = 1'b0;
    fifo_data  = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, then reset with a word ready and enable high: no pop.
    run(3);
    fifo_q.push_back(8'h55);
    tx_enable = 1'b1;
    drive_fifo();
    run(2);

    // Single word 0x55 after reset release.
    rst_n    = 1'b1;
    busy_cnt = 0;
    run(FRAME + 4);
    check("busy_cycles_55", busy_cnt, FRAME);

    // Upper FIFO bit ignored.
    fifo_q.push_back(8'hC1);
    drive_fifo();
    run(FRAME + 4);

    // Back-to-back words: pops spaced one full frame plus one idle cycle.
    pop_cyc.delete();
    fifo_q.push_back(8'h11);
    fifo_q.push_back(8'h22);
    fifo_q.push_back(8'h33);
    drive_fifo();
    run(3 * (FRAME + 1) + 5);
    check("b2b_pop_count", pop_cyc.size(), 3);
    if (pop_cyc.size() == 3) begin
      check("b2b_gap1", pop_cyc[1] - pop_cyc[0], FRAME + 1);
      check("b2b_gap2", pop_cyc[2] - pop_cyc[1], FRAME + 1);
    end

    // Empty FIFO, then disabled transmitter, 100 cycles each.
    busy_cnt  = 0;
    fifo_gate = 1'b0;
    fifo_q.push_back(8'hA5);
    drive_fifo();
    run(100);
    fifo_gate = 1'b1;
    tx_enable = 1'b0;
    drive_fifo();
    run(100);
    check("busy_while_blocked", busy_cnt, 0);

    // Enable toggles mid-frame neither abort nor extend the frame.
    tx_enable = 1'b1;
    run(10);
    tx_enable = 1'b0;
    fifo_q.push_back(8'h5A);
    drive_fifo();
    run(FRAME + 10);
    tx_enable = 1'b1;
    run(12);
    tx_enable = 1'b0;
    run(3);
    tx_enable = 1'b1;
    run(FRAME);

    // Randomized words, gaps, FIFO-empty gating and enable toggling.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 29) == 0) fifo_q.push_back(WS'($urandom));
      tx_enable = ($urandom_range(0, 7) != 0);
      fifo_gate = ($urandom_range(0, 9) != 0);
      drive_fifo();
      cycle();
    end
    fifo_gate = 1'b1;
    tx_enable = 1'b1;
    drive_fifo();
    guard = 0;
    while ((fifo_q.size() > 0 || exp_q.size() > 0) && guard < 3000) begin
      cycle();
      guard++;
    end
    check("drain_fifo_empty", fifo_q.size(), 0);
    check("drain_frames_done", exp_q.size(), 0);

    // Reset for one cycle during DATA abandons the frame; next word goes out.
    fifo_q.push_back(8'h6A);
    fifo_q.push_back(8'h3C);
    drive_fifo();
    start_pops = model_pops;
    guard = 0;
    while (model_pops == start_pops && guard < 100) begin
      cycle();
      guard++;
    end
    check("reset_test_popped", model_pops - start_pops, 1);
    run(CPB + 2 * CPB);
    rst_n = 1'b0;
    run(1);
    rst_n = 1'b1;
    run(FRAME + 8);
    check("reset_test_fifo_empty", fifo_q.size(), 0);

    check("pop_count", dut_pops, model_pops);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
  p_word_size  8  width of the word read from the transmit FIFO
  p_data_bits  7  data bits per frame (7N1 framing)
  p_clks_per_bit  16  clk_i cycles per bit period, minimum 2
REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
  clk_i  input  1  single clock
  rst_n_i  input  1  reset, synchronous, active-low
  fifo_data_i  input  p_word_size  head word of the upstream first-word-fall-through FIFO
  fifo_valid_i  input  1  FIFO not empty; fifo_data_i is valid
  fifo_read_o  output  1  one-cycle pop strobe to the FIFO
  tx_enable_i  input  1  permits starting a new frame
  tx_o  output  1  serial line, idle high
  busy_o  output  1  frame in progress

Function
REQ-003 The FSM SHALL have states IDLE, START, DATA and STOP.
REQ-004 fifo_read_o SHALL be combinational and equal (state==IDLE) & fifo_valid_i & tx_enable_i & rst_n_i.
REQ-005 On the edge where fifo_read_o=1, fifo_data_i[p_data_bits-1:0] SHALL be latched into the shift register, and the state SHALL go IDLE->START.
REQ-006 Bits fifo_data_i[p_word_size-1:p_data_bits] SHALL be ignored.
REQ-007 tx_o SHALL be registered: 1 in IDLE and STOP, 0 in START, and the current shift-register LSB in DATA.
REQ-008 Each of START, each data bit, and STOP SHALL last exactly p_clks_per_bit cycles, timed by a baud counter that restarts at 0 on every state entry.
REQ-009 Data SHALL be sent LSB first; a bit counter SHALL run 0..p_data_bits-1, with DATA->STOP after the last bit's period.
REQ-010 STOP->IDLE SHALL occur after one stop-bit period, giving a minimum frame-to-frame period of (p_data_bits+2)*p_clks_per_bit+1 cycles.
REQ-011 The first tx_o low cycle SHALL follow the pop edge by exactly one cycle.
REQ-012 busy_o SHALL be 1 in every state other than IDLE.
REQ-013 Exactly one pop SHALL occur per frame, with no pop while busy_o=1.
REQ-014 If fifo_valid_i=0 in IDLE, the block SHALL hold IDLE with tx_o=1 indefinitely.
REQ-015 Deasserting tx_enable_i mid-frame SHALL NOT abort the frame; it only blocks the next start.
REQ-016 Changes on fifo_data_i after the pop SHALL NOT affect the frame in progress.

Reset
REQ-017 While rst_n_i=0 at a clk_i edge: state=IDLE, tx_o=1, busy_o=0, counters=0, and shift register=0.
REQ-018 fifo_read_o SHALL be 0 whenever rst_n_i=0, regardless of state.
REQ-019 Reset mid-frame SHALL abandon the frame: tx_o=1 from the next edge, and the popped word is lost.

Structure
REQ-020 Package uart_pkg SHALL hold the FSM state enum typedef and the default constants for data bits and clocks per bit.
REQ-021 Baud timing SHALL be a sub-module, uart_baud_counter: a counter with a restart input and an end-of-period output, sized $clog2(p_clks_per_bit).
REQ-022 The bit counter SHALL be sized $clog2(p_data_bits).

Verification (p_clks_per_bit=4, p_data_bits=7)
REQ-023 Single word: FIFO holds 0x55, tx_enable_i=1 -> one pop cycle; tx_o = 0 for 4 cycles, then 1,0,1,0,1,0,1 for 4 cycles each, then 1 for 4 cycles; busy_o high for 36 cycles.
REQ-024 Upper bit ignored: 0xC1 -> data bits 1,0,0,0,0,0,1 (0x41).
REQ-025 Back-to-back: 0x11, 0x22, 0x33 queued -> three pops spaced 37 cycles apart, frames in order, no extra pops.
REQ-026 Empty or disabled: fifo_valid_i=0 or tx_enable_i=0 for 100 cycles -> fifo_read_o=0, tx_o=1, busy_o=0 throughout; raising tx_enable_i mid-frame has no effect on that frame.
REQ-027 Reset mid-frame: rst_n_i=0 for 1 cycle during the DATA state -> next edge tx_o=1, busy_o=0, state IDLE; fifo_read_o=0 during the reset cycle; the next queued word transmits normally.
